cq_issue_select: RTL and testbench

- Dequeue-side controller for a bank of condition-queue entries.
- Each cycle it looks at every entry's ready-to-dequeue flag and picks the oldest ready entry by allocation order.
- The picked entry's payload goes into a registered issue stage with a valid/ready handshake.
- On handshake acceptance it pulses the one-hot clear that empties the issued entry. Sits between the condition-queue entry array and the execution-unit dispatch port.

---
 rtl/cq_issue_select_if.sv | 38 +++
 rtl/cq_issue_select.sv | 119 +++++++++++
 tb/tb_cq_issue_select.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cq_issue_select_if.sv
// Dequeue-side bundle between the condition-queue entry array, the issue stage and the dispatch port.
// The master modport is the select block; the slave modport is its environment.
interface cq_issue_select_if #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned INDEX_WIDTH = 4
);
   localparam int unsigned ID_WIDTH = $clog2(NUM_ENTRIES);

   logic                               alloc_valid;
   logic [ID_WIDTH-1:0]                alloc_id;
   logic [NUM_ENTRIES-1:0]             entry_ready_vec;
   logic [NUM_ENTRIES*DATA_WIDTH-1:0]  entry_data_flat;
   logic [NUM_ENTRIES*INDEX_WIDTH-1:0] entry_index_flat;
   logic                               flush;
   logic                               issue_valid;
   logic                               issue_ready;
   logic [DATA_WIDTH-1:0]              issue_data;
   logic [INDEX_WIDTH-1:0]             issue_index;
   logic [ID_WIDTH-1:0]                issue_entry_id;
   logic [NUM_ENTRIES-1:0]             clear_entry_vec;
   logic [31:0]                        perf_issue_cnt;
   logic [31:0]                        perf_stall_cnt;

   modport master (
      input  alloc_valid, alloc_id, entry_ready_vec, entry_data_flat, entry_index_flat, flush,
             issue_ready,
      output issue_valid, issue_data, issue_index, issue_entry_id, clear_entry_vec,
             perf_issue_cnt, perf_stall_cnt
   );

   modport slave (
      output alloc_valid, alloc_id, entry_ready_vec, entry_data_flat, entry_index_flat, flush,
             issue_ready,
      input  issue_valid, issue_data, issue_index, issue_entry_id, clear_entry_vec,
             perf_issue_cnt, perf_stall_cnt
   );
endinterface

// File: rtl/cq_issue_select.sv
// Oldest-ready entry select into a registered valid/ready issue stage with one-hot clear on accept.
// Define CQ_SELECT_PERF_EN to build the issue/stall performance counters.
module cq_issue_select #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned INDEX_WIDTH = 4
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   cq_issue_select_if.master io
);
   localparam int unsigned IdW = $clog2(NUM_ENTRIES);

   // age_q[i][j] set means entry i is older than entry j
   logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];

   logic                   valid_q;
   logic [DATA_WIDTH-1:0]  data_q;
   logic [INDEX_WIDTH-1:0] index_q;
   logic [IdW-1:0]         id_q;

   logic [NUM_ENTRIES-1:0] held, cand, sel, clear;
   logic                   found, load, accept;
   logic [IdW-1:0]         sel_id;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [INDEX_WIDTH-1:0] sel_index;

   always_comb begin
      held = '0;
      if (valid_q) held[id_q] = 1'b1;
      cand = io.entry_ready_vec & ~held;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         sel[i] = cand[i];
         for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
            if (j != i && cand[j] && age_q[j][i]) sel[i] = 1'b0;
         end
      end
      // Several winners only exist before ordering is established; lowest id takes it
      found     = 1'b0;
      sel_id    = '0;
      sel_data  = '0;
      sel_index = '0;
      for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
         if (sel[i]) begin
            found     = 1'b1;
            sel_id    = IdW'(i);
            sel_data  = io.entry_data_flat[i*DATA_WIDTH +: DATA_WIDTH];
            sel_index = io.entry_index_flat[i*INDEX_WIDTH +: INDEX_WIDTH];
         end
      end
   end

   always_comb begin
      accept = valid_q & io.issue_ready & ~io.flush;
      load   = ~valid_q | io.issue_ready;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         clear[i] = accept & (id_q == IdW'(i));
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         age_d[i] = age_q[i];
         if (io.alloc_valid) begin
            if (io.alloc_id == IdW'(i)) age_d[i] = '0;
            else age_d[i][io.alloc_id] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         age_q   <= '{default: '0};
         valid_q <= 1'b0;
         data_q  <= '0;
         index_q <= '0;
         id_q    <= '0;
      end else begin
         age_q <= age_d;
         if (io.flush) begin
            valid_q <= 1'b0;
         end else if (load) begin
            valid_q <= found;
            if (found) begin
               data_q  <= sel_data;
               index_q <= sel_index;
               id_q    <= sel_id;
            end
         end
      end
   end

   assign io.issue_valid     = valid_q;
   assign io.issue_data      = data_q;
   assign io.issue_index     = index_q;
   assign io.issue_entry_id  = id_q;
   assign io.clear_entry_vec = clear;

`ifdef CQ_SELECT_PERF_EN
   logic [31:0] issue_cnt_q, stall_cnt_q;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept) issue_cnt_q <= issue_cnt_q + 32'd1;
         if (valid_q && !io.issue_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign io.perf_issue_cnt = issue_cnt_q;
   assign io.perf_stall_cnt = stall_cnt_q;
`else
   assign io.perf_issue_cnt = '0;
   assign io.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cq_issue_select.sv
// Bench for cq_issue_select: directed scenarios plus random traffic against an allocation-stamp model.
module tb_cq_issue_select;
   localparam int unsigned N   = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned IW  = 4;
   localparam int unsigned IDW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cq_issue_select_if #(.NUM_ENTRIES(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

   cq_issue_select #(.NUM_ENTRIES(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
      .clock_i (clk),
      .reset_ni(rst_n),
      .io      (bus.master)
   );

   logic [DW-1:0] ent_data  [N];
   logic [IW-1:0] ent_index [N];

   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         bus.entry_data_flat[i*DW +: DW]  = ent_data[i];
         bus.entry_index_flat[i*IW +: IW] = ent_index[i];
      end
   end

   // Model: each entry carries an allocation stamp; smaller stamp is older, equal stamps tie on id
   int unsigned stamp [N];
   int unsigned seq;
   bit          m_valid;
   int          m_id;
   logic [DW-1:0] m_data;
   logic [IW-1:0] m_index;
   logic [31:0] m_issue, m_stall;

   int errors = 0;
   int checks = 0;

   function automatic int pick_oldest();
      int best = -1;
      for (int i = 0; i < int'(N); i++) begin
         if (bus.entry_ready_vec[i] && !(m_valid && m_id == i)) begin
            if (best < 0 || stamp[i] < stamp[best]) best = i;
         end
      end
      return best;
   endfunction

   function automatic logic [N-1:0] exp_clear();
      logic [N-1:0] c = '0;
      if (m_valid && bus.issue_ready && !bus.flush) c[m_id] = 1'b1;
      return c;
   endfunction

   function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef CQ_SELECT_PERF_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(N); i++) stamp[i] = 0;
      seq = 0; m_valid = 0; m_id = 0; m_data = '0; m_index = '0;
      m_issue = '0; m_stall = '0;
   endtask

   task automatic tick();
      int p;
      bit nv; int nid; logic [DW-1:0] nd; logic [IW-1:0] ni;
      p = pick_oldest();
      nv = m_valid; nid = m_id; nd = m_data; ni = m_index;
      if (m_valid && bus.issue_ready && !bus.flush) m_issue = m_issue + 32'd1;
      if (m_valid && !bus.issue_ready) m_stall = m_stall + 32'd1;
      if (bus.flush) nv = 0;
      else if (!m_valid || bus.issue_ready) begin
         if (p >= 0) begin
            nv = 1; nid = p; nd = ent_data[p]; ni = ent_index[p];
         end else nv = 0;
      end
      if (bus.alloc_valid) begin
         seq++;
         stamp[bus.alloc_id] = seq;
      end
      @(posedge clk);
      m_valid = nv; m_id = nid; m_data = nd; m_index = ni;
      #1;
   endtask

   task automatic idle_inputs();
      bus.alloc_valid = 0; bus.alloc_id = '0; bus.entry_ready_vec = '0;
      bus.flush = 0; bus.issue_ready = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      for (int i = 0; i < int'(N); i++) begin
         ent_data[i] = $urandom; ent_index[i] = IW'($urandom);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.issue_valid !== 1'b0) begin errors++;
         $display("FAIL reset_valid: got %b want 0", bus.issue_valid); end
      checks++; if (bus.issue_data !== '0 || bus.issue_index !== '0 || bus.issue_entry_id !== '0) begin
         errors++; $display("FAIL reset_payload: got %h/%h/%0d want 0/0/0",
                            bus.issue_data, bus.issue_index, bus.issue_entry_id); end
      checks++; if (bus.clear_entry_vec !== '0) begin errors++;
         $display("FAIL reset_clear: got %b want 0", bus.clear_entry_vec); end
      checks++; if (bus.perf_issue_cnt !== '0 || bus.perf_stall_cnt !== '0) begin errors++;
         $display("FAIL reset_perf: got %0d/%0d want 0/0", bus.perf_issue_cnt, bus.perf_stall_cnt); end
   endtask

   task automatic test_tie_break();
      bus.entry_ready_vec = 8'b0010_0100;
      bus.issue_ready = 1;
      #1;
      checks++; if (bus.issue_valid !== 1'b0) begin errors++;
         $display("FAIL tie_pre_valid: got %b want 0", bus.issue_valid); end
      tick();
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_entry_id !== 3'd2) begin errors++;
         $display("FAIL tie_id: got v=%b id=%0d want v=1 id=2", bus.issue_valid, bus.issue_entry_id); end
      checks++; if (bus.issue_data !== ent_data[2] || bus.issue_index !== ent_index[2]) begin errors++;
         $display("FAIL tie_data: got %h/%h want %h/%h", bus.issue_data, bus.issue_index,
                  ent_data[2], ent_index[2]); end
      checks++; if (bus.clear_entry_vec !== 8'b0000_0100) begin errors++;
         $display("FAIL tie_clear: got %b want 00000100", bus.clear_entry_vec); end
      tick();
      bus.entry_ready_vec = 8'b0010_0000;
      #1;
      checks++; if (bus.issue_entry_id !== 3'd5 || bus.clear_entry_vec !== 8'b0010_0000) begin errors++;
         $display("FAIL tie_second: got id=%0d clr=%b want id=5 clr=00100000",
                  bus.issue_entry_id, bus.clear_entry_vec); end
      tick();
      bus.entry_ready_vec = '0;
      #1;
      checks++; if (bus.issue_valid !== 1'b0) begin errors++;
         $display("FAIL tie_drain: got %b want 0", bus.issue_valid); end
   endtask

   task automatic test_age_order();
      int order [3] = '{6, 1, 3};
      bus.issue_ready = 1;
      for (int k = 0; k < 3; k++) begin
         bus.alloc_valid = 1; bus.alloc_id = IDW'(order[k]);
         tick();
      end
      bus.alloc_valid = 0;
      bus.entry_ready_vec = 8'b0100_1010;
      #1;
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++; if (bus.issue_valid !== 1'b1 || bus.issue_entry_id !== IDW'(order[k])) begin
            errors++; $display("FAIL age_order[%0d]: got v=%b id=%0d want v=1 id=%0d", k,
                               bus.issue_valid, bus.issue_entry_id, order[k]); end
         checks++; if (bus.clear_entry_vec !== (8'h01 << order[k])) begin errors++;
            $display("FAIL age_clear[%0d]: got %h want %h", k, bus.clear_entry_vec,
                     8'h01 << order[k]); end
         tick();
         bus.entry_ready_vec[order[k]] = 1'b0;
         #1;
      end
      checks++; if (bus.issue_valid !== 1'b0) begin errors++;
         $display("FAIL age_drain: got %b want 0", bus.issue_valid); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held_data;
      logic [IW-1:0] held_index;
      bus.entry_ready_vec = 8'b0001_0000;
      bus.issue_ready = 0;
      #1;
      tick();
      held_data = ent_data[4];
      held_index = ent_index[4];
      for (int k = 0; k < 3; k++) begin
         ent_data[4] = $urandom; ent_index[4] = IW'($urandom);
         #1;
         checks++; if (bus.issue_valid !== 1'b1 || bus.issue_entry_id !== 3'd4 ||
                       bus.issue_data !== held_data || bus.issue_index !== held_index) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h i=%h want 1/4/%h/%h", k,
                               bus.issue_valid, bus.issue_entry_id, bus.issue_data,
                               bus.issue_index, held_data, held_index); end
         checks++; if (bus.clear_entry_vec !== '0) begin errors++;
            $display("FAIL bp_clear[%0d]: got %b want 0", k, bus.clear_entry_vec); end
         tick();
      end
      checks++; if (bus.perf_stall_cnt !== exp_perf(m_stall)) begin errors++;
         $display("FAIL bp_stall_cnt: got %0d want %0d", bus.perf_stall_cnt, exp_perf(m_stall)); end
      bus.issue_ready = 1;
      #1;
      checks++; if (bus.clear_entry_vec !== 8'b0001_0000) begin errors++;
         $display("FAIL bp_release: got %b want 00010000", bus.clear_entry_vec); end
      tick();
      bus.entry_ready_vec = '0;
      tick();
   endtask

   task automatic test_flush();
      bus.entry_ready_vec = 8'b0000_0001;
      bus.issue_ready = 1;
      #1;
      tick();
      bus.flush = 1;
      #1;
      checks++; if (bus.issue_valid !== 1'b1 || bus.clear_entry_vec !== '0) begin errors++;
         $display("FAIL flush_clear: got v=%b clr=%b want v=1 clr=0", bus.issue_valid,
                  bus.clear_entry_vec); end
      tick();
      bus.flush = 0;
      #1;
      checks++; if (bus.issue_valid !== 1'b0) begin errors++;
         $display("FAIL flush_valid: got %b want 0", bus.issue_valid); end
      tick();
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_entry_id !== 3'd0) begin errors++;
         $display("FAIL flush_reselect: got v=%b id=%0d want v=1 id=0", bus.issue_valid,
                  bus.issue_entry_id); end
      bus.entry_ready_vec = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.entry_ready_vec = 8'b0000_0010;
      bus.issue_ready = 0;
      #1;
      tick();
      bus.issue_ready = 1;
      #2;
      rst_n = 0;
      #1;
      checks++; if (bus.issue_valid !== 1'b0 || bus.clear_entry_vec !== '0) begin errors++;
         $display("FAIL rst_mid: got v=%b clr=%b want v=0 clr=0", bus.issue_valid,
                  bus.clear_entry_vec); end
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1;
      bus.entry_ready_vec = 8'b1000_1000;
      bus.issue_ready = 1;
      #1;
      tick();
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_entry_id !== 3'd3) begin errors++;
         $display("FAIL rst_tiebreak: got v=%b id=%0d want v=1 id=3", bus.issue_valid,
                  bus.issue_entry_id); end
      bus.entry_ready_vec = '0;
      tick();
      tick();
   endtask

   task automatic test_perf();
      do_reset();
      bus.issue_ready = 1;
      for (int k = 0; k < 11; k++) begin
         bus.entry_ready_vec = '0;
         if (k < 10) bus.entry_ready_vec[k % int'(N)] = 1'b1;
         #1;
         tick();
      end
      checks++; if (bus.perf_issue_cnt !== exp_perf(m_issue)) begin errors++;
         $display("FAIL perf_issue: got %0d want %0d", bus.perf_issue_cnt, exp_perf(m_issue)); end
      checks++; if (bus.perf_stall_cnt !== exp_perf(m_stall)) begin errors++;
         $display("FAIL perf_stall: got %0d want %0d", bus.perf_stall_cnt, exp_perf(m_stall)); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < int'(N); i++) begin
            ent_data[i] = $urandom; ent_index[i] = IW'($urandom);
         end
         bus.entry_ready_vec = N'($urandom);
         bus.alloc_valid = ($urandom_range(2) == 0);
         bus.alloc_id = IDW'($urandom_range(N - 1));
         if (m_valid && bus.alloc_id == IDW'(m_id)) bus.alloc_valid = 0;
         bus.flush = ($urandom_range(7) == 0);
         bus.issue_ready = ($urandom_range(2) != 0);
         #1;
         checks++;
         if (bus.issue_valid !== m_valid ||
             (m_valid && (bus.issue_entry_id !== IDW'(m_id) || bus.issue_data !== m_data ||
                          bus.issue_index !== m_index)) ||
             bus.clear_entry_vec !== exp_clear() ||
             bus.perf_issue_cnt !== exp_perf(m_issue) ||
             bus.perf_stall_cnt !== exp_perf(m_stall)) begin
            errors++;
            if (bad < 10) $display("FAIL rand[%0d]: got v=%b id=%0d d=%h i=%h clr=%b pi=%0d ps=%0d want v=%b id=%0d d=%h i=%h clr=%b pi=%0d ps=%0d",
               c, bus.issue_valid, bus.issue_entry_id, bus.issue_data, bus.issue_index,
               bus.clear_entry_vec, bus.perf_issue_cnt, bus.perf_stall_cnt, m_valid, m_id,
               m_data, m_index, exp_clear(), exp_perf(m_issue), exp_perf(m_stall));
            bad++;
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_tie_break();
      test_age_order();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
